// File: rtl/rvsteel_dma.sv
// Single-channel word-copy DMA: four control registers on the device port, word reads/writes on its own manager port.
// Latency: register accesses answer one cycle after the request; each word costs read latency + write latency (4 cycles at 1-cycle targets), plus one FIN cycle.
// Backpressure: manager requests hold address/data/strobe stable until the target responds, waiting indefinitely.
module rvsteel_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  // Register (device) port
  input  logic [31:0] rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  // Manager port
  output logic [31:0] m_rw_address,
  input  logic [31:0] m_read_data,
  output logic        m_read_request,
  input  logic        m_read_response,
  output logic [31:0] m_write_data,
  output logic [3:0]  m_write_strobe,
  output logic        m_write_request,
  input  logic        m_write_response,
  // Interrupt
  output logic        irq,
  input  logic        irq_response
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          buf_q, buf_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 done_q, done_d;
  logic                 ie_q, ie_d;
  logic                 abort_q, abort_d;
  logic                 read_response_q, write_response_q;
  logic [31:0]          read_data_q, read_data_d;

  logic [1:0] reg_sel;
  logic       reg_wr;
  logic       wr_ctrl;
  logic       busy;
  logic       start_req;
  logic       abort_set;
  logic       abort_pending;
  logic       done_clr;
  logic       unused_addr_bits;

  // Only word offsets are decoded; partial-word writes are acknowledged but discarded.
  assign reg_sel          = rw_address[3:2];
  assign unused_addr_bits = ^{rw_address[31:4], rw_address[1:0]};
  assign reg_wr           = write_request && (write_strobe == 4'hF);
  assign wr_ctrl          = reg_wr && (reg_sel == REG_CTRL);
  assign busy             = (state_q == ST_RD) || (state_q == ST_WR);
  assign start_req        = wr_ctrl && write_data[0];
  // Abort only matters while a copy is in flight; it is honoured at the next write-response boundary.
  assign abort_set        = wr_ctrl && write_data[4] && busy;
  assign abort_pending    = abort_q || abort_set;
  assign done_clr         = (wr_ctrl && write_data[2]) || irq_response;

  // Copy engine next state, address/count bookkeeping and programmable register writes
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    buf_d   = buf_q;
    abort_d = abort_q;

    // Address/count registers are frozen while the engine owns them.
    if (reg_wr && !busy) begin
      case (reg_sel)
        REG_SRC: src_d = {write_data[31:2], 2'b00};
        REG_DST: dst_d = {write_data[31:2], 2'b00};
        REG_LEN: len_d = write_data[LEN_WIDTH-1:0];
        default: ;
      endcase
    end

    if (abort_set) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // A zero-length start completes without touching the bus.
        if (start_req) begin
          state_d = (len_q != '0) ? ST_RD : ST_FIN;
        end
      end
      ST_RD: begin
        if (m_read_response) begin
          buf_d   = m_read_data;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (m_write_response) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          len_d   = len_q - LEN_WIDTH'(1);
          state_d = ((len_q == LEN_WIDTH'(1)) || abort_pending) ? ST_FIN : ST_RD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end
    endcase
  end

  // DONE/IE flags: completion beats a simultaneous clear so an interrupt is never lost
  always_comb begin
    done_d = done_q;
    ie_d   = ie_q;
    if (wr_ctrl) begin
      ie_d = write_data[3];
    end
    if (done_clr) begin
      done_d = 1'b0;
    end
    if (state_q == ST_FIN) begin
      done_d = 1'b1;
    end
  end

  // Register read mux; data is presented only in the response cycle
  always_comb begin
    read_data_d = 32'd0;
    if (read_request) begin
      case (reg_sel)
        REG_SRC:  read_data_d = src_q;
        REG_DST:  read_data_d = dst_q;
        REG_LEN:  read_data_d = 32'(len_q);
        default:  read_data_d = {27'd0, 1'b0, ie_q, done_q, busy, 1'b0};
      endcase
    end
  end

  // State registers; reset abandons any outstanding manager request on the next edge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      src_q            <= 32'd0;
      dst_q            <= 32'd0;
      buf_q            <= 32'd0;
      len_q            <= '0;
      done_q           <= 1'b0;
      ie_q             <= 1'b0;
      abort_q          <= 1'b0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      read_data_q      <= 32'd0;
    end else begin
      state_q          <= state_d;
      src_q            <= src_d;
      dst_q            <= dst_d;
      buf_q            <= buf_d;
      len_q            <= len_d;
      done_q           <= done_d;
      ie_q             <= ie_d;
      abort_q          <= abort_d;
      read_response_q  <= read_request;
      write_response_q <= write_request;
      read_data_q      <= read_data_d;
    end
  end

  assign read_response   = read_response_q;
  assign write_response  = write_response_q;
  assign read_data       = read_data_q;

  // Manager outputs decode straight from state so they are stable for the whole request.
  assign m_read_request  = (state_q == ST_RD);
  assign m_write_request = (state_q == ST_WR);
  assign m_rw_address    = (state_q == ST_RD) ? src_q :
                           (state_q == ST_WR) ? dst_q : 32'd0;
  assign m_write_data    = (state_q == ST_WR) ? buf_q : 32'd0;
  assign m_write_strobe  = (state_q == ST_WR) ? 4'hF : 4'h0;

  assign irq             = done_q && ie_q;

endmodule

// File: tb/tb_rvsteel_dma.sv
// Bench for rvsteel_dma: register table vectors, timed corner-case sequences, randomized copies vs. a memory model.
// Latency: manager target answers after a programmable or random number of cycles.
// Backpressure: target stalls are modelled by delaying the response; the DUT must hold its request.
module tb_rvsteel_dma;

  logic        clock;
  logic        reset;
  logic [31:0] rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic [31:0] m_rw_address;
  logic [31:0] m_read_data;
  logic        m_read_request;
  logic        m_read_response;
  logic [31:0] m_write_data;
  logic [3:0]  m_write_strobe;
  logic        m_write_request;
  logic        m_write_response;
  logic        irq;
  logic        irq_response;

  rvsteel_dma #(.LEN_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response),
    .write_data(write_data), .write_strobe(write_strobe),
    .write_request(write_request), .write_response(write_response),
    .m_rw_address(m_rw_address), .m_read_data(m_read_data),
    .m_read_request(m_read_request), .m_read_response(m_read_response),
    .m_write_data(m_write_data), .m_write_strobe(m_write_strobe),
    .m_write_request(m_write_request), .m_write_response(m_write_response),
    .irq(irq), .irq_response(irq_response)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Target memory and write log shared by the responder and the checks
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  int          rd_lat = 1;
  int          wr_lat = 1;
  bit          rand_lat = 1'b0;
  int          hs_viol = 0;
  int          req_seen = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    rw_address    = a;
    write_data    = d;
    write_strobe  = s;
    write_request = 1'b1;
    tick();
    write_request = 1'b0;
    write_strobe  = 4'h0;
    check("wr_ack", {31'd0, write_response}, 32'd1);
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    rw_address   = a;
    read_request = 1'b1;
    tick();
    read_request = 1'b0;
    check("rd_ack", {31'd0, read_response}, 32'd1);
    d = read_data;
  endtask

  task automatic wait_done();
    logic [31:0] d;
    int n;
    d = 32'd0;
    n = 0;
    while (d[2] == 1'b0 && n < 400) begin
      reg_read(32'hC, d);
      n++;
    end
    check("done_wait", {31'd0, d[2]}, 32'd1);
  endtask

  // Manager-side target: answers after a latency, checks request stability and exclusivity
  int          cnt;
  int          cur_lat;
  bit          cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  initial begin
    m_read_response  = 1'b0;
    m_write_response = 1'b0;
    m_read_data      = 32'd0;
    cnt = 0;
    cur_lat = 1;
    forever begin
      tick();
      if (reset) begin
        m_read_response  = 1'b0;
        m_write_response = 1'b0;
        m_read_data      = 32'd0;
        cnt = 0;
      end else begin
        if (m_read_response || m_write_response) begin
          m_read_response  = 1'b0;
          m_write_response = 1'b0;
          m_read_data      = 32'd0;
          cnt = 0;
        end
        if (m_read_request && m_write_request) hs_viol++;
        if (m_write_request && m_write_strobe != 4'hF) hs_viol++;
        if (!m_write_request && m_write_strobe != 4'h0) hs_viol++;
        if (m_read_request || m_write_request) begin
          if (m_rw_address[1:0] != 2'b00) hs_viol++;
          if (cnt == 0) begin
            cur_wr   = m_write_request;
            cur_addr = m_rw_address;
            cur_data = m_write_data;
            if (rand_lat) cur_lat = int'($urandom_range(1, 3));
            else          cur_lat = m_write_request ? wr_lat : rd_lat;
            req_seen++;
          end else if (cur_wr != m_write_request || cur_addr != m_rw_address ||
                       (cur_wr && cur_data != m_write_data)) begin
            hs_viol++;
          end
          if (cnt >= cur_lat) begin
            if (cur_wr) begin
              mem[cur_addr] = cur_data;
              wlog_addr.push_back(cur_addr);
              wlog_data.push_back(cur_data);
              m_write_response = 1'b1;
            end else begin
              m_read_data     = mem_rd(cur_addr);
              m_read_response = 1'b1;
            end
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [16];

  logic [31:0] d;
  int          n;
  int          req_before;
  int          rd_cyc;
  int          addr_bad;
  int          early_wr;
  logic [31:0] s_addr;
  logic [31:0] d_addr;
  int          wlen;
  logic [31:0] exp_q [$];
  logic [31:0] w;

  initial begin
    tbl[0]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h4,        32'h0,        4'h0, 32'h0};
    tbl[2]  = '{1'b0, 32'h8,        32'h0,        4'h0, 32'h0};
    tbl[3]  = '{1'b0, 32'hC,        32'h0,        4'h0, 32'h0};
    tbl[4]  = '{1'b1, 32'h0,        32'h12345677, 4'hF, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h12345674};
    tbl[6]  = '{1'b1, 32'hFFFFFF04, 32'hFFFFFFFF, 4'hF, 32'h0};
    tbl[7]  = '{1'b0, 32'h4,        32'h0,        4'h0, 32'hFFFFFFFC};
    tbl[8]  = '{1'b1, 32'h8,        32'hABCD1234, 4'hF, 32'h0};
    tbl[9]  = '{1'b0, 32'h8,        32'h0,        4'h0, 32'h00001234};
    tbl[10] = '{1'b1, 32'h0,        32'h0,        4'h7, 32'h0};
    tbl[11] = '{1'b0, 32'h0,        32'h0,        4'h0, 32'h12345674};
    tbl[12] = '{1'b1, 32'hC,        32'h18,       4'hF, 32'h0};
    tbl[13] = '{1'b0, 32'hC,        32'h0,        4'h0, 32'h8};
    tbl[14] = '{1'b1, 32'hC,        32'h4,        4'hF, 32'h0};
    tbl[15] = '{1'b0, 32'hC,        32'h0,        4'h0, 32'h0};

    reset = 1'b1;
    rw_address = 32'd0; write_data = 32'd0; write_strobe = 4'h0;
    read_request = 1'b0; write_request = 1'b0; irq_response = 1'b0;
    repeat (3) tick();

    // Reset state of every output
    check("rst_m_rd_req", {31'd0, m_read_request}, 32'd0);
    check("rst_m_wr_req", {31'd0, m_write_request}, 32'd0);
    check("rst_m_addr", m_rw_address, 32'd0);
    check("rst_m_wdata", m_write_data, 32'd0);
    check("rst_m_strb", {28'd0, m_write_strobe}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_resps", {30'd0, read_response, write_response}, 32'd0);
    reset = 1'b0;
    tick();

    // Register map vectors
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        reg_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      end else begin
        reg_read(tbl[i].addr, d);
        check($sformatf("tbl%0d", i), d, tbl[i].exp);
      end
    end
    tick();
    check("rdata_idle_zero", read_data, 32'd0);

    // Three-word copy with exact completion timing
    mem[32'h100] = 32'hA1; mem[32'h104] = 32'hB2; mem[32'h108] = 32'hC3;
    reg_write(32'h0, 32'h100, 4'hF);
    reg_write(32'h4, 32'h200, 4'hF);
    reg_write(32'h8, 32'd3, 4'hF);
    wlog_addr.delete(); wlog_data.delete();
    reg_write(32'hC, 32'h9, 4'hF);
    n = 1;
    while (!irq && n < 100) begin tick(); n++; end
    check("copy3_done_cycle", n, 32'd14);
    check("copy3_d0", mem_rd(32'h200), 32'hA1);
    check("copy3_d1", mem_rd(32'h204), 32'hB2);
    check("copy3_d2", mem_rd(32'h208), 32'hC3);
    check("copy3_nwr", wlog_addr.size(), 32'd3);
    reg_read(32'h0, d); check("copy3_src", d, 32'h10C);
    reg_read(32'h4, d); check("copy3_dst", d, 32'h20C);
    reg_read(32'h8, d); check("copy3_len", d, 32'h0);
    reg_read(32'hC, d); check("copy3_ctrl", d, 32'hC);

    // Interrupt acknowledge clears DONE and drops irq the next cycle
    check("irq_before_ack", {31'd0, irq}, 32'd1);
    irq_response = 1'b1;
    tick();
    irq_response = 1'b0;
    check("irq_after_ack", {31'd0, irq}, 32'd0);

    // DONE clear written in the FIN cycle loses to the set
    mem[32'h180] = 32'h55;
    reg_write(32'h0, 32'h180, 4'hF);
    reg_write(32'h4, 32'h280, 4'hF);
    reg_write(32'h8, 32'd1, 4'hF);
    reg_write(32'hC, 32'h9, 4'hF);
    repeat (4) tick();
    check("fin_no_req", {30'd0, m_read_request, m_write_request}, 32'd0);
    reg_write(32'hC, 32'hC, 4'hF);
    check("fin_w1c_irq", {31'd0, irq}, 32'd1);
    reg_read(32'hC, d); check("fin_w1c_ctrl", d, 32'hC);
    reg_write(32'hC, 32'h4, 4'hF);
    reg_read(32'hC, d); check("w1c_clear", d, 32'h0);

    // Zero-length start: FIN directly, no bus traffic
    reg_write(32'h8, 32'd0, 4'hF);
    req_before = req_seen;
    reg_write(32'hC, 32'h9, 4'hF);
    reg_read(32'hC, d);
    check("len0_ctrl_nobusy", d, 32'h8);
    check("len0_irq", {31'd0, irq}, 32'd1);
    repeat (3) tick();
    check("len0_no_req", req_seen, req_before);
    reg_write(32'hC, 32'h4, 4'hF);

    // Register writes and re-START while busy are acknowledged but ignored
    rd_lat = 2; wr_lat = 2;
    for (int i = 0; i < 4; i++) mem[32'h300 + 32'(4 * i)] = 32'h3000 + 32'(i);
    reg_write(32'h0, 32'h300, 4'hF);
    reg_write(32'h4, 32'h400, 4'hF);
    reg_write(32'h8, 32'd4, 4'hF);
    wlog_addr.delete(); wlog_data.delete();
    reg_write(32'hC, 32'h1, 4'hF);
    reg_write(32'h0, 32'hDEAD0000, 4'hF);
    reg_write(32'hC, 32'h1, 4'hF);
    reg_write(32'h8, 32'd5, 4'hF);
    wait_done();
    check("busy_nwr", wlog_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
      check($sformatf("busy_wa%0d", i), wlog_addr[i], 32'h400 + 32'(4 * i));
      check($sformatf("busy_wd%0d", i), wlog_data[i], 32'h3000 + 32'(i));
    end
    reg_read(32'h0, d); check("busy_src", d, 32'h310);
    reg_read(32'h4, d); check("busy_dst", d, 32'h410);
    reg_read(32'h8, d); check("busy_len", d, 32'h0);
    reg_write(32'hC, 32'h4, 4'hF);

    // Read response stalled: request and address held for 6 cycles, no early write
    rd_lat = 5; wr_lat = 1;
    mem[32'h500] = 32'hCAFEF00D;
    reg_write(32'h0, 32'h500, 4'hF);
    reg_write(32'h4, 32'h580, 4'hF);
    reg_write(32'h8, 32'd1, 4'hF);
    wlog_addr.delete(); wlog_data.delete();
    reg_write(32'hC, 32'h1, 4'hF);
    rd_cyc = 0; addr_bad = 0; early_wr = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_read_request) begin
        rd_cyc++;
        if (m_rw_address != 32'h500) addr_bad++;
      end
      if (m_write_request && rd_cyc < 6) early_wr++;
      tick();
    end
    check("stall_rd_cycles", rd_cyc, 32'd6);
    check("stall_addr_held", addr_bad, 32'd0);
    check("stall_no_early_wr", early_wr, 32'd0);
    check("stall_wdata", mem_rd(32'h580), 32'hCAFEF00D);
    reg_read(32'hC, d); check("stall_done", d, 32'h4);
    reg_write(32'hC, 32'h4, 4'hF);
    rd_lat = 1;

    // Abort during the second read: two writes complete, LEN=8
    for (int i = 0; i < 10; i++) mem[32'h600 + 32'(4 * i)] = 32'h6000 + 32'(i);
    reg_write(32'h0, 32'h600, 4'hF);
    reg_write(32'h4, 32'h700, 4'hF);
    reg_write(32'h8, 32'd10, 4'hF);
    wlog_addr.delete(); wlog_data.delete();
    reg_write(32'hC, 32'h1, 4'hF);
    n = 0;
    while (!(m_read_request && wlog_addr.size() == 1) && n < 50) begin tick(); n++; end
    check("abort_sync", {31'd0, n < 50}, 32'd1);
    reg_write(32'hC, 32'h10, 4'hF);
    wait_done();
    check("abort_nwr", wlog_addr.size(), 32'd2);
    reg_read(32'h8, d); check("abort_len", d, 32'd8);
    reg_read(32'h0, d); check("abort_src", d, 32'h608);
    reg_read(32'hC, d); check("abort_ctrl", d, 32'h4);
    reg_write(32'hC, 32'h4, 4'hF);

    // Randomized copies against a word-copy reference model (first one wraps SRC past 2^32)
    rand_lat = 1'b1;
    for (int it = 0; it < 8; it++) begin
      if (it == 0) begin
        s_addr = 32'hFFFFFFF8;
        wlen   = 4;
      end else begin
        s_addr = $urandom & 32'hFFFFFFFC;
        wlen   = int'($urandom_range(1, 6));
      end
      d_addr = s_addr ^ 32'h80000000;
      exp_q.delete();
      for (int i = 0; i < wlen; i++) begin
        w = $urandom;
        mem[s_addr + 32'(4 * i)] = w;
        exp_q.push_back(w);
      end
      reg_write(32'h0, s_addr, 4'hF);
      reg_write(32'h4, d_addr, 4'hF);
      reg_write(32'h8, 32'(wlen), 4'hF);
      wlog_addr.delete(); wlog_data.delete();
      reg_write(32'hC, 32'h1, 4'hF);
      wait_done();
      check($sformatf("rnd%0d_nwr", it), wlog_addr.size(), 32'(wlen));
      for (int i = 0; i < wlen && i < wlog_addr.size(); i++) begin
        check($sformatf("rnd%0d_wa%0d", it, i), wlog_addr[i], d_addr + 32'(4 * i));
        check($sformatf("rnd%0d_wd%0d", it, i), wlog_data[i], exp_q[i]);
      end
      reg_read(32'h0, d); check($sformatf("rnd%0d_src", it), d, s_addr + 32'(4 * wlen));
      reg_read(32'h4, d); check($sformatf("rnd%0d_dst", it), d, d_addr + 32'(4 * wlen));
      reg_read(32'h8, d); check($sformatf("rnd%0d_len", it), d, 32'd0);
      reg_write(32'hC, 32'h4, 4'hF);
    end
    rand_lat = 1'b0;

    // Reset in the middle of a write: all outputs idle next cycle, DONE stays clear
    wr_lat = 10;
    reg_write(32'h0, 32'h800, 4'hF);
    reg_write(32'h4, 32'h900, 4'hF);
    reg_write(32'h8, 32'd2, 4'hF);
    reg_write(32'hC, 32'h9, 4'hF);
    n = 0;
    while (!m_write_request && n < 50) begin tick(); n++; end
    check("rstwr_in_wr", {31'd0, m_write_request}, 32'd1);
    reset = 1'b1;
    tick();
    check("rstwr_m_rd_req", {31'd0, m_read_request}, 32'd0);
    check("rstwr_m_wr_req", {31'd0, m_write_request}, 32'd0);
    check("rstwr_m_addr", m_rw_address, 32'd0);
    check("rstwr_m_wdata", m_write_data, 32'd0);
    check("rstwr_m_strb", {28'd0, m_write_strobe}, 32'd0);
    check("rstwr_irq", {31'd0, irq}, 32'd0);
    check("rstwr_rdata", read_data, 32'd0);
    reset = 1'b0;
    wr_lat = 1;
    tick();
    reg_read(32'hC, d); check("rstwr_ctrl", d, 32'h0);
    reg_read(32'h8, d); check("rstwr_len", d, 32'h0);

    check("handshake_violations", hs_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
